// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
// Bus widths, FSM encodings and the PC alignment helper.
package if_stage_pkg;

    localparam int ADDR_BUS = 64;
    localparam int INST_BUS = 32;

    localparam logic [ADDR_BUS-1:0] ZERO_64      = '0;
    localparam logic [ADDR_BUS-1:0] RESET_PC_VAL = 64'h0000_0000_3000_0000;

    localparam logic [1:0] IF_REQ  = 2'd0;
    localparam logic [1:0] IF_WAIT = 2'd1;
    localparam logic [1:0] IF_DROP = 2'd2;

    function automatic logic [ADDR_BUS-1:0] align_pc(
        input logic [ADDR_BUS-1:0] pc
    );
        return {pc[ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry PC+instruction holding buffer used while decode stalls.
// Clear and drain both empty it; clear wins over load.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                drain,
    input  logic                clear,
    input  logic [ADDR_BUS-1:0] load_pc,
    input  logic [INST_BUS-1:0] load_inst,
    output logic                valid,
    output logic [ADDR_BUS-1:0] pc,
    output logic [INST_BUS-1:0] inst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= ZERO_64;
            inst  <= '0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding bus request, stale-response
// dropping on redirect, and the decode pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC = RESET_PC_VAL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallD,
    input  logic                flushD,
    input  logic                redirectValid,
    input  logic [ADDR_BUS-1:0] redirectPc,
    output logic                instReqValid,
    input  logic                instReqReady,
    output logic [ADDR_BUS-1:0] instReqAddr,
    input  logic                instRespValid,
    input  logic [INST_BUS-1:0] instRespData,
    output logic [ADDR_BUS-1:0] pcD,
    output logic [INST_BUS-1:0] instD
);

    logic [1:0]          state;
    logic [ADDR_BUS-1:0] pc_f;
    logic [ADDR_BUS-1:0] req_pc;
    logic [ADDR_BUS-1:0] redirect_tgt;
    logic                req_fire;
    logic                deliver;
    logic                buf_load;
    logic                buf_drain;
    logic                buf_valid;
    logic [ADDR_BUS-1:0] buf_pc;
    logic [INST_BUS-1:0] buf_inst;

    assign redirect_tgt = align_pc(redirectPc);

    // Gated by reset so nothing is requested while the core is held.
    assign instReqValid = rst & (state == IF_REQ) & ~buf_valid;
    assign instReqAddr  = pc_f;
    assign req_fire     = instReqValid & instReqReady;

    assign deliver   = (state == IF_WAIT) & instRespValid & ~redirectValid;
    assign buf_load  = deliver & (stallD | flushD);
    assign buf_drain = buf_valid & ~flushD & ~stallD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IF_REQ;
            pc_f   <= RESET_PC;
            req_pc <= ZERO_64;
        end else begin
            if (redirectValid) begin
                pc_f <= redirect_tgt;
            end else if (deliver) begin
                pc_f <= req_pc + 64'd4;
            end
            case (state)
                IF_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc_f;
                        state  <= redirectValid ? IF_DROP : IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (instRespValid) begin
                        state <= IF_REQ;
                    end else if (redirectValid) begin
                        state <= IF_DROP;
                    end
                end
                IF_DROP: begin
                    if (instRespValid) begin
                        state <= IF_REQ;
                    end
                end
                default: state <= IF_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcD   <= ZERO_64;
            instD <= '0;
        end else if (flushD) begin
            pcD   <= ZERO_64;
            instD <= '0;
        end else if (!stallD) begin
            if (buf_valid) begin
                pcD   <= buf_pc;
                instD <= buf_inst;
            end else if (deliver) begin
                pcD   <= req_pc;
                instD <= instRespData;
            end else begin
                pcD   <= ZERO_64;
                instD <= '0;
            end
        end
    end

    if_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .load      (buf_load),
        .drain     (buf_drain),
        .clear     (redirectValid),
        .load_pc   (req_pc),
        .load_inst (instRespData),
        .valid     (buf_valid),
        .pc        (buf_pc),
        .inst      (buf_inst)
    );

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage against a request-queue reference model.
// Bus latency, ready, stall, flush and redirect are all randomised.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD, flushD, redirectValid;
    logic [63:0] redirectPc;
    logic        instReqValid, instReqReady;
    logic [63:0] instReqAddr;
    logic        instRespValid;
    logic [31:0] instRespData;
    logic [63:0] pcD;
    logic [31:0] instD;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stallD        (stallD),
        .flushD        (flushD),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .instReqValid  (instReqValid),
        .instReqReady  (instReqReady),
        .instReqAddr   (instReqAddr),
        .instRespValid (instRespValid),
        .instRespData  (instRespData),
        .pcD           (pcD),
        .instD         (instD)
    );

    int total = 0;
    int bad   = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        bit          stale;
        int          dly;
    } req_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        pend[$];
    ent_t        bufq[$];
    logic [63:0] m_pc;
    logic [63:0] m_pcd;
    logic [31:0] m_instd;

    int p_ready, p_stall, p_flush, p_redir, max_dly;

    task automatic model_reset();
        pend.delete();
        bufq.delete();
        m_pc    = 64'h0000_0000_3000_0000;
        m_pcd   = '0;
        m_instd = '0;
    endtask

    task automatic knobs(input int r, input int s, input int f,
                         input int d, input int l);
        p_ready = r; p_stall = s; p_flush = f; p_redir = d; max_dly = l;
    endtask

    task automatic run_cycles(input int n);
        bit          exp_req, hs, resp, deliver;
        ent_t        e;
        req_t        r;
        logic [63:0] old_pc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stallD        = ($urandom % 100) < p_stall;
            flushD        = ($urandom % 100) < p_flush;
            redirectValid = ($urandom % 100) < p_redir;
            redirectPc    = {$urandom, $urandom};
            instReqReady  = ($urandom % 100) < p_ready;
            instRespData  = $urandom;
            resp = 1'b0;
            if (pend.size() > 0) begin
                if (pend[0].dly == 0) resp = 1'b1;
                else pend[0].dly--;
            end
            instRespValid = resp;
            #1;
            exp_req = (pend.size() == 0) && (bufq.size() == 0);
            expect_eq("req_valid", 64'(instReqValid), 64'(exp_req));
            if (exp_req) expect_eq("req_addr", instReqAddr, m_pc);
            expect_eq("pcD", pcD, m_pcd);
            expect_eq("instD", 64'(instD), 64'(m_instd));

            hs      = exp_req && instReqReady;
            deliver = resp && !pend[0].stale && !redirectValid;
            if (resp) begin
                e.pc   = pend[0].addr;
                e.inst = instRespData;
                void'(pend.pop_front());
            end
            if (flushD) begin
                m_pcd = '0; m_instd = '0;
                if (deliver) bufq.push_back(e);
            end else if (stallD) begin
                if (deliver) bufq.push_back(e);
            end else if (bufq.size() > 0) begin
                e = bufq.pop_front();
                m_pcd = e.pc; m_instd = e.inst;
            end else if (deliver) begin
                m_pcd = e.pc; m_instd = e.inst;
            end else begin
                m_pcd = '0; m_instd = '0;
            end
            old_pc = m_pc;
            if (redirectValid) begin
                bufq.delete();
                foreach (pend[k]) pend[k].stale = 1'b1;
                m_pc = {redirectPc[63:2], 2'b00};
            end else if (deliver) begin
                m_pc = e.pc + 64'd4;
            end
            if (hs) begin
                r.addr  = old_pc;
                r.stale = redirectValid;
                r.dly   = $urandom_range(0, max_dly);
                pend.push_back(r);
            end
        end
    endtask

    task automatic idle_inputs();
        stallD = 0; flushD = 0; redirectValid = 0; redirectPc = '0;
        instReqReady = 0; instRespValid = 0; instRespData = '0;
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) begin
            @(negedge clk);
            expect_eq("rst_req_valid", 64'(instReqValid), 64'd0);
            expect_eq("rst_pcD", pcD, 64'd0);
            expect_eq("rst_instD", 64'(instD), 64'd0);
        end
        rst = 1'b1;

        knobs(100, 0, 0, 0, 0);   run_cycles(10);
        knobs(100, 30, 0, 0, 0);  run_cycles(200);
        knobs(70, 20, 10, 10, 3); run_cycles(2000);
        knobs(20, 10, 5, 15, 4);  run_cycles(1000);
        knobs(80, 40, 30, 5, 1);  run_cycles(1000);

        // Reset while a request is outstanding; the late response must vanish.
        knobs(100, 0, 0, 0, 3);
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            run_cycles(1);
            found = pend.size() > 0;
        end
        expect_eq("pending_found", 64'(found), 64'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        expect_eq("mid_rst_req_valid", 64'(instReqValid), 64'd0);
        expect_eq("mid_rst_instD", 64'(instD), 64'd0);
        @(negedge clk);
        instRespValid = 1'b1;
        instRespData  = 32'hdead_beef;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        instRespValid = 1'b1;
        #1;
        expect_eq("post_rst_req_valid", 64'(instReqValid), 64'd1);
        expect_eq("post_rst_addr", instReqAddr, 64'h3000_0000);
        @(negedge clk);
        instRespValid = 1'b0;
        #1;
        expect_eq("stray_instD", 64'(instD), 64'd0);
        expect_eq("stray_pcD", pcD, 64'd0);
        expect_eq("stray_addr", instReqAddr, 64'h3000_0000);

        knobs(60, 25, 10, 8, 2);  run_cycles(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the five-stage core. Holds the fetch PC and issues one 32-bit instruction request at a time on the instruction bus. Delivers each returned instruction with its PC into the decode pipeline register (`pcD`/`instD`) consumed by the decode stage. Honours decode stall/flush, takes PC redirects from branch/jump/trap resolution, and discards responses to stale requests.

## Interface
- `RESET_PC`, default 64'h0000_0000_3000_0000: first fetch address after reset.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stallD`  in  1  hold `pcD`/`instD`; the decode register does not advance.
- `flushD`  in  1  replace decode-register contents with a bubble.
- `redirectValid`  in  1  PC redirect request (taken branch, jump, trap, mret).
- `redirectPc`  in  64 (`ADDR_BUS`)  redirect target; bits [1:0] forced to 0.
- `instReqValid`  out  1  instruction request valid.
- `instReqReady`  in  1  bus accepts the request.
- `instReqAddr`  out  64  request address.
- `instRespValid`  in  1  response valid, exactly one per accepted request, no backpressure.
- `instRespData`  in  32 (`INST_BUS`)  instruction word.
- `pcD`  out  64  PC of the instruction in the decode register.
- `instD`  out  32  instruction in the decode register; 0 = bubble.

## Operation
- Registers: `pcF` (next fetch PC), `reqPc` (PC of the outstanding request), one-entry skid buffer (`bufValid`, `bufPc`, `bufInst`), decode register (`pcD`, `instD`).
- FSM states: REQ, WAIT, DROP.
  - REQ: `instReqValid = ~bufValid`, `instReqAddr = pcF`. On valid&ready: `reqPc <= pcF` and go to WAIT. If `redirectValid` arrives in the same cycle, also go to DROP instead of WAIT and set `pcF <= redirectPc`. If `redirectValid` arrives without a handshake: `pcF <= redirectPc` and stay in REQ; the address may change while valid.
  - WAIT: on `instRespValid` without redirect: `pcF <= reqPc+4`, deliver `{reqPc, instRespData}`, go to REQ. If redirect arrives with the response: drop the response, `pcF <= redirectPc`, go to REQ. If redirect arrives without a response: `pcF <= redirectPc`, go to DROP.
  - DROP: on `instRespValid`, drop the response and go to REQ. A redirect here only updates `pcF`.
- Delivery and decode-register update, in priority order:
  - `flushD` → `pcD <= 0`, `instD <= 0`.
  - Else `stallD` → hold. A delivered response goes into the skid buffer.
  - Else, if the buffer is valid → load from the buffer and clear it.
  - Else, if a response is delivered → load it.
  - Otherwise → bubble (0, 0).
- `redirectValid` clears the skid buffer in the same edge.
- No new request is issued while `bufValid`, so at most one instruction is in flight beyond the decode register.
- PC arithmetic is 64-bit wrapping.

## Timing
- Reset values:
  - State REQ, `pcF = RESET_PC`.
  - `pcD = 0`, `instD = 0`, `bufValid = 0`.
  - `instReqValid = 0` while `rst` is low. It is 1 from the first cycle after deassertion.
- Reset mid-transaction: all state is cleared and any later response is ignored, because the FSM is in REQ and not WAIT.
- Latency: a response at edge N appears on `instD` after edge N when `stallD = 0`.
- Peak throughput is one instruction per 2 cycles, with a zero-wait bus (REQ, then WAIT).
- `instReqValid`/`instReqAddr` are combinational from state, `pcF` and `bufValid`. All other outputs are registered.
- Simultaneous `flushD` and `stallD`: the flush wins. A response in that cycle still goes to the buffer unless `redirectValid` is also asserted.

## Structure
- `defines.v`:
  - Provides `ADDR_BUS`, `INST_BUS` and `ZERO_64`.
  - Add the FSM state encodings `IF_REQ`, `IF_WAIT`, `IF_DROP` and the default `RESET_PC_VAL` there.
- One sub-module, `if_skid_buf`: the one-entry PC+instruction buffer with load/drain/clear inputs and an asynchronous active-low reset.
- The FSM, PC logic and decode register live in `if_stage`.

## Test plan
- **Reset:** hold `rst` low 3 cycles, then release; bus always ready, 1-cycle response.
  - While `rst` is low: `instReqValid = 0`, `pcD = 0`, `instD = 0`.
  - First request address is 0x3000_0000, then 0x3000_0004, 0x3000_0008.
  - `instD` shows each word 2 cycles apart.
- **Stall with buffering:** assert `stallD` 4 cycles while the response for 0x3000_0004 arrives.
  - Instruction is held in the buffer and `instReqValid = 0`.
  - After release, `pcD = 0x3000_0004` on the next edge, then fetch resumes at 0x3000_0008.
- **Redirect during WAIT:** `redirectPc = 0x3000_0100` while a request to 0x3000_0008 is outstanding.
  - The stale response is dropped; `instD` never shows it.
  - Next request is to 0x3000_0100.
- **Redirect coinciding with response:** the response is dropped, `pcF = redirect target`, and the next request is issued the following cycle.
- **Flush over stall:** assert `flushD` and `stallD` together → `instD = 0`, `pcD = 0` next cycle. A response arriving that cycle is kept in the buffer and delivered after release.
- **Slow bus:** `instReqReady` low 5 cycles, redirect on cycle 2 → the address changes to the redirect target and the handshake completes with it.
